serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around a single 1-bit full-adder cell plus a carry flip-flop; processes one bit per clock, LSB first.
- Sits directly upstream of, and drives, the team's existing 1-bit full-adder cell.
  - It sequences the operand bits into the cell's a/b inputs.
  - It registers the cell's carry-out back into cin each cycle.
- Provides the area-minimal adder option for the datapath; a start/done handshake connects it to the control unit.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2 to 64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new addition; sampled on rising clk
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- cin  input  1  initial carry-in; captured when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result is valid
- z  output  WIDTH  sum; held stable from done until the next accepted start
- cout  output  1  final carry-out
- ovf  output  1  signed overflow = carry into MSB XOR cout

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy, done, z, cout, ovf, carry FF, bit counter and operand shift registers are all 0.
  - Released reset takes effect at the next clk edge.
- States:
  - IDLE: busy=0, done=0. On a clk edge with start=1:
    - load A_sh=a, B_sh=b, carry=cin, cnt=0;
    - clear the z shift register;
    - go to RUN.
  - RUN: busy=1. Each edge:
    - the full-adder cell sums A_sh[0], B_sh[0] and carry;
    - the sum bit shifts into z from the MSB end (z <= {sum, z[WIDTH-1:1]});
    - carry <= cell carry-out;
    - A_sh and B_sh shift right by 1;
    - cnt increments.
    - On the edge processing bit WIDTH-1 (cnt == WIDTH-1):
      - also latch ovf = carry_in_to_MSB XOR carry_out_of_MSB;
      - cout <= carry-out;
      - go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 on this edge behaves as in IDLE (back-to-back operation allowed).
    - Otherwise go to IDLE.
- Latency: start accepted at edge E0; busy is high after E0 through EWIDTH; done is high during the cycle after EWIDTH. Result is therefore WIDTH+1 cycles after start acceptance. Throughput is one add per WIDTH+1 cycles.
- start while in RUN: ignored. No abort; a, b and cin are not resampled.
- a, b and cin may change freely after the accepting edge.
- z, cout and ovf:
  - change only during RUN and on reset;
  - intermediate z values during RUN are not meaningful;
  - they hold the last result through IDLE.
- Arithmetic:
  - z = (a + b + cin) mod 2^WIDTH;
  - cout = bit WIDTH of the full sum;
  - unsigned and two's-complement results are identical; ovf applies to the signed interpretation only.
- cnt width is clog2(WIDTH). cnt never wraps mid-operation; it resets to 0 on each accepted start.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0. No done pulse is produced for the aborted operation.

Test Plan:
- WIDTH=8, a=8'h35, b=8'h4A, cin=0, start for 1 cycle -> busy high 8 cycles, then done pulse 1 cycle; z=8'h7F, cout=0, ovf=0.
- a=8'hFF, b=8'h01, cin=0 -> z=8'h00, cout=1, ovf=0. Then a=8'hFF, b=8'h00, cin=1 -> z=8'h00, cout=1.
- a=8'h7F, b=8'h01, cin=0 -> z=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 -> z=8'h00, cout=1, ovf=1.
- start held high continuously with operand pairs (1,2) then (3,4) -> done pulses 9 cycles apart; z=3 then z=7. Operands changed during RUN and start pulses during RUN have no effect.
- Assert rst_n low for 1 cycle at RUN bit 4 of a=8'hAA, b=8'h55 -> busy, done, z, cout and ovf go 0 immediately with no done pulse. A fresh start then yields z=8'hFF, cout=0.
- Randomized: 1000 (a, b, cin) triples at WIDTH=8 and WIDTH=32 -> z/cout/ovf match the reference sum every time; done is exactly one cycle wide; z is stable until the next start.

Source files
------------

// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Groups the control-unit handshake and operand/result buses of the
//   bit-serial adder.
//   master : control unit side (drives start/a/b/cin, observes the results)
//   slave  : adder side (observes start/a/b/cin, drives busy/done/z/cout/ovf)
//   Signals:
//     start       request a new addition, sampled on rising clk
//     a, b, cin   operands and initial carry, captured when start is accepted
//     busy        high while bits are being processed
//     done        one-cycle pulse when the result is valid
//     z           WIDTH-bit sum, held from done until the next accepted start
//     cout        final carry-out
//     ovf         signed overflow (carry into MSB XOR carry out of MSB)
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, z, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, z, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder: one 1-bit full-adder cell plus a carry
//   flip-flop, processing one operand bit per clock, LSB first.
//   A start accepted at edge E0 keeps busy high through edge E(WIDTH); done
//   pulses for the following cycle, so one add takes WIDTH+1 cycles.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    serial_adder_if slave modport (start/a/b/cin in,
//            busy/done/z/cout/ovf out)

// 1-bit full-adder cell driven by the sequencer below.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s;
  logic fa_co;

  serial_adder_fa u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts start exactly like IDLE to allow back-to-back adds.
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          z_d     = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        z_d     = {fa_s, z_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB; fa_co the carry out of it.
          ovf_d   = carry_q ^ fa_co;
          cout_d  = fa_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    bus.busy = busy_q;
    bus.done = done_q;
    bus.z    = z_q;
    bus.cout = cout_q;
    bus.ovf  = ovf_q;
  end

endmodule
